// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector: controller states
// and the default sizing used by the top level and the history sub-module.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_det_ctrl_hist.sv
// Serial bit history and pattern compare. The window presented to the
// comparator is the stored history with the current bit appended, so a hit
// is reported in the same cycle the completing bit arrives.
module seq_hist
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               valid,
  input  logic               clear,
  input  logic [3:0]         len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               hit
);

  // Only MAX_LEN-1 past bits are ever needed; the newest bit comes from bit_in.
  logic [MAX_LEN-2:0] hist_q;
  logic [MAX_LEN-2:0] hist_d;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;

  // Compare window, length mask, next history and hit flag.
  always_comb begin
    window = {hist_q, bit_in};
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit    = (((window ^ pattern) & mask) == '0);
    hist_d = hist_q;
    if (clear) begin
      hist_d = '0;
    end else if (valid) begin
      hist_d = window[MAX_LEN-2:0];
    end
  end

  // History register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Configurable serial sequence detector controller. A configuration is
// latched in IDLE; a run shifts serial bits through seq_hist, counts
// matches (overlapping or not) and optionally ends when a target count is
// reached. match is a Mealy output valid in the same cycle as the bit.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               in_seq,
  input  logic               in_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

  localparam int                FILL_W   = $clog2(MAX_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);

  state_e             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [3:0]         len_q, len_d;
  logic               ov_q, ov_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;

  logic               run;
  logic               hist_valid;
  logic               hist_clear;
  logic               hit;
  logic               fill_ok;
  logic [CNT_W:0]     cnt_inc;
  logic               tgt_hit;

  seq_hist #(.MAX_LEN(MAX_LEN)) u_hist (
    .clk     (clk),
    .rst     (rst),
    .bit_in  (in_seq),
    .valid   (hist_valid),
    .clear   (hist_clear),
    .len     (len_q),
    .pattern (pat_q),
    .hit     (hit)
  );

  // Match qualification; the count increment is one bit wider so the
  // saturation point and the target compare never wrap.
  always_comb begin
    run        = (state_q == ST_RUN);
    hist_valid = run & in_valid;
    hist_clear = ~run & start & ~cfg_valid & ~stop;
    fill_ok    = ((int'(fill_q) + 1) >= int'(len_q));
    match      = hist_valid & hit & fill_ok;
    cnt_inc    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    tgt_hit    = match & (tgt_q != '0) & (cnt_inc == {1'b0, tgt_q});
    cfg_ready  = ~run;
    busy       = run;
    done       = done_q;
    cfg_err    = err_q;
    match_cnt  = cnt_q;
  end

  // Next-state logic: configuration handshake, run start/stop, fill and count.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pat_d   = pat_q;
    len_d   = len_q;
    ov_d    = ov_q;
    tgt_d   = tgt_q;
    if (state_q == ST_IDLE) begin
      if (cfg_valid) begin
        if ((cfg_len != 4'd0) && (int'(cfg_len) <= MAX_LEN)) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          ov_d  = cfg_overlap;
          tgt_d = cfg_target;
        end else begin
          err_d = 1'b1;
        end
      end else if (start && !stop) begin
        state_d = ST_RUN;
        fill_d  = '0;
        cnt_d   = '0;
      end
    end else begin
      if (in_valid) begin
        if (match && !ov_q) begin
          fill_d = '0;
        end else if (fill_q != FILL_MAX) begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
      if (match && !cnt_inc[CNT_W]) begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
      if (tgt_hit) begin
        done_d = 1'b1;
      end
      if (stop || tgt_hit) begin
        state_d = ST_IDLE;
      end
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pat_q   <= '0;
      len_q   <= 4'd1;
      ov_q    <= 1'b1;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ov_q    <= ov_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against a behavioural model.
// A second instance with a 2-bit counter shares the stimulus.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = 4'd1;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_target = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in_seq = 1'b0;
  logic       in_valid = 1'b0;

  logic       cfg_ready, cfg_err, match, busy, done;
  logic [7:0] match_cnt;
  logic       cfg_ready2, cfg_err2, match2, busy2, done2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_det_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start), .stop(stop),
    .in_seq(in_seq), .in_valid(in_valid), .match(match),
    .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  seq_det_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target[1:0]), .cfg_err(cfg_err2), .start(start), .stop(stop),
    .in_seq(in_seq), .in_valid(in_valid), .match(match2),
    .match_cnt(match_cnt2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Behavioural model, one copy per instance (index 1 = 2-bit counter).
  int m_run[2], m_cnt[2], m_done[2], m_err[2], m_hist[2], m_fill[2];
  int m_pat[2], m_len[2], m_ov[2], m_tgt[2];
  int cmax[2] = '{255, 3};

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int a_match, a_cnt, a_busy, a_done, a_err, a_rdy;
        int exp_m, err_n, done_n, endr, win;
        a_match = (i == 0) ? int'(match)     : int'(match2);
        a_cnt   = (i == 0) ? int'(match_cnt) : int'(match_cnt2);
        a_busy  = (i == 0) ? int'(busy)      : int'(busy2);
        a_done  = (i == 0) ? int'(done)      : int'(done2);
        a_err   = (i == 0) ? int'(cfg_err)   : int'(cfg_err2);
        a_rdy   = (i == 0) ? int'(cfg_ready) : int'(cfg_ready2);
        if (!rst) begin
          m_run[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_err[i] = 0;
          m_hist[i] = 0; m_fill[i] = 0; m_pat[i] = 0; m_len[i] = 1;
          m_ov[i] = 1; m_tgt[i] = 0;
        end
        win = (m_hist[i] << 1) | int'(in_seq);
        exp_m = (m_run[i] != 0 && in_valid && (m_fill[i] + 1 >= m_len[i]) &&
                 (((win ^ m_pat[i]) % (1 << m_len[i])) == 0)) ? 1 : 0;
        chk($sformatf("cyc_match_u%0d", i), a_match, exp_m);
        chk($sformatf("cyc_cnt_u%0d", i), a_cnt, m_cnt[i]);
        chk($sformatf("cyc_busy_u%0d", i), a_busy, m_run[i]);
        chk($sformatf("cyc_done_u%0d", i), a_done, m_done[i]);
        chk($sformatf("cyc_err_u%0d", i), a_err, m_err[i]);
        chk($sformatf("cyc_ready_u%0d", i), a_rdy, (m_run[i] != 0) ? 0 : 1);
        if (rst) begin
          err_n = 0; done_n = 0;
          if (m_run[i] == 0) begin
            if (cfg_valid) begin
              if (cfg_len >= 1 && cfg_len <= 8) begin
                m_pat[i] = int'(cfg_pattern);
                m_len[i] = int'(cfg_len);
                m_ov[i]  = int'(cfg_overlap);
                m_tgt[i] = int'(cfg_target) % (cmax[i] + 1);
              end else begin
                err_n = 1;
              end
            end else if (start && !stop) begin
              m_run[i] = 1; m_hist[i] = 0; m_fill[i] = 0; m_cnt[i] = 0;
            end
          end else begin
            endr = stop ? 1 : 0;
            if (in_valid) begin
              m_hist[i] = win % 256;
              if (exp_m != 0 && m_ov[i] == 0) m_fill[i] = 0;
              else if (m_fill[i] < 8) m_fill[i] = m_fill[i] + 1;
            end
            if (exp_m != 0) begin
              if (m_tgt[i] != 0 && m_cnt[i] + 1 == m_tgt[i]) begin
                done_n = 1; endr = 1;
              end
              if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            end
            if (endr != 0) m_run[i] = 0;
          end
          m_err[i] = err_n;
          m_done[i] = done_n;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                           input logic ov, input logic [7:0] tgt);
    step();
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ov; cfg_target = tgt;
  endtask

  task automatic go();
    step();
    start = 1'b1;
  endtask

  task automatic end_run();
    step();
    stop = 1'b1;
    step();
  endtask

  task automatic run_stream(input string tag, input logic [15:0] bits,
                            input int n, input logic [15:0] expm);
    for (int i = 0; i < n; i++) begin
      step();
      in_valid = 1'b1;
      in_seq = bits[i];
      #2;
      chk($sformatf("%s_match_bit%0d", tag, i + 1), match, expm[i]);
    end
    step();
  endtask

  initial begin
    // Reset state
    step(); step();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_ready", cfg_ready, 1);
    step();
    rst = 1'b1;

    // Overlapping detection of 10110
    configure(8'b0001_0110, 4'd5, 1'b1, 8'd0);
    go();
    run_stream("ovl", 16'h006D, 8, 16'h0090);
    #2; chk("ovl_cnt", match_cnt, 2);
    end_run();
    #2; chk("ovl_busy_after_stop", busy, 0);

    // Non-overlapping detection, same stream
    configure(8'b0001_0110, 4'd5, 1'b0, 8'd0);
    go();
    run_stream("novl", 16'h006D, 8, 16'h0010);
    #2; chk("novl_cnt", match_cnt, 1);
    end_run();

    // Rejected configurations keep the previous one
    configure(8'b0000_0101, 4'd4, 1'b0, 8'd3);
    configure(8'hFF, 4'd0, 1'b1, 8'd1);
    step(); #2; chk("len0_err", cfg_err, 1);
    step(); #2; chk("len0_err_clear", cfg_err, 0);
    configure(8'hFF, 4'd9, 1'b1, 8'd1);
    step(); #2; chk("len9_err", cfg_err, 1);
    step(); #2; chk("len9_err_clear", cfg_err, 0);
    go();
    run_stream("keep", 16'h000A, 4, 16'h0008);
    #2; chk("keep_cnt", match_cnt, 1);
    chk("keep_busy", busy, 1);
    end_run();

    // Target count ends the run
    configure(8'b0000_0011, 4'd2, 1'b1, 8'd2);
    go();
    run_stream("tgt", 16'h0007, 3, 16'h0006);
    #2; chk("tgt_done", done, 1);
    chk("tgt_busy", busy, 0);
    chk("tgt_cnt", match_cnt, 2);
    step(); #2; chk("tgt_done_pulse", done, 0);

    // Counter saturation on the 2-bit instance
    configure(8'b0000_0001, 4'd1, 1'b1, 8'd0);
    go();
    run_stream("sat", 16'h003F, 6, 16'h003F);
    #2; chk("sat_cnt2", match_cnt2, 3);
    chk("sat_cnt8", match_cnt, 6);
    end_run();

    // Reset mid-run
    configure(8'b0000_0101, 4'd3, 1'b1, 8'd0);
    go();
    run_stream("mid", 16'h0005, 3, 16'h0004);
    rst = 1'b0;
    in_valid = 1'b1; in_seq = 1'b1;
    #2;
    chk("midrst_match", match, 0);
    chk("midrst_cnt", match_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", cfg_err, 0);
    step();
    rst = 1'b1;
    configure(8'b0000_0101, 4'd3, 1'b1, 8'd0);
    go();
    run_stream("restart", 16'h0001, 2, 16'h0000);
    #2; chk("restart_cnt", match_cnt, 0);
    end_run();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 12))
                                            : 4'($urandom_range(1, 3));
      cfg_pattern = 8'($urandom);
      cfg_overlap = 1'($urandom);
      cfg_target = 8'($urandom_range(0, 4));
      start = ($urandom_range(0, 5) == 0);
      stop = ($urandom_range(0, 24) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_seq = 1'($urandom);
    end
    step();
    rst = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 8, width of match counter and target.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cfg_valid  input  1  configuration offer.
REQ-006 SHALL have port cfg_ready  output  1  high only in IDLE; the configuration is accepted when cfg_valid and cfg_ready are both high.
REQ-007 SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit 0 is the last serial bit.
REQ-008 SHALL have port cfg_len  input  4  pattern length.
REQ-009 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-010 SHALL have port cfg_target  input  CNT_W  match count that ends a run; 0 = run until stop.
REQ-011 SHALL have port cfg_err  output  1  one-cycle pulse when a configuration is rejected.
REQ-012 SHALL have port start  input  1  begin a detection run.
REQ-013 SHALL have port stop  input  1  abort the run.
REQ-014 SHALL have port in_seq  input  1  serial data bit.
REQ-015 SHALL have port in_valid  input  1  in_seq is sampled this cycle.
REQ-016 SHALL have port match  output  1  Mealy output, combinational from in_seq, in_valid and state.
REQ-017 SHALL have port match_cnt  output  CNT_W  saturating count of matches.
REQ-018 SHALL have port busy  output  1  high in RUN.
REQ-019 SHALL have port done  output  1  one-cycle pulse when the target count is reached.

Function
REQ-020 SHALL implement the states IDLE and RUN.
REQ-021 SHALL accept a configuration only in IDLE, when cfg_len is between 1 and MAX_LEN inclusive; otherwise it SHALL pulse cfg_err the next cycle and retain the previous configuration.
REQ-022 SHALL transition IDLE->RUN on start when cfg_valid and stop are both low; on the transition it SHALL clear the bit history, the history fill count and match_cnt.
REQ-023 SHALL, when start and stop are asserted together in IDLE, let stop win and remain in IDLE.
REQ-024 SHALL, in RUN on each in_valid cycle, shift in_seq into the history and increment the fill count, saturating at MAX_LEN.
REQ-025 SHALL assert match in the same cycle, in RUN, when in_valid is high, fill+1 >= cfg_len, and the low cfg_len bits of {history, in_seq} equal the low cfg_len bits of cfg_pattern.
REQ-026 SHALL, in non-overlap mode, reset the fill count to 0 after a match; in overlap mode it SHALL keep the history unchanged.
REQ-027 SHALL increment match_cnt on each match and saturate it at 2^CNT_W-1.
REQ-028 SHALL, when cfg_target != 0 and match_cnt+1 == cfg_target on a match, pulse done the next cycle and return to IDLE.
REQ-029 SHALL, on stop in RUN, return to IDLE the next cycle; a match in that same cycle SHALL still assert and be counted.
REQ-030 SHALL ignore in_valid in IDLE, keep match low there, and hold match_cnt until the next start.

Reset
REQ-031 SHALL, on rst low, immediately force the state to IDLE and drive busy=0, done=0, cfg_err=0, match=0, match_cnt=0, history=0, fill=0, pattern=0, len=1, overlap=1, target=0.
REQ-032 SHALL, after reset is asserted mid-run, discard all progress and leave no residual match.

Structure
REQ-033 SHALL take its state enum and the MAX_LEN/CNT_W defaults from a shared package named seq_det_pkg.
REQ-034 SHALL implement the shift history and compare in one sub-module, seq_hist, whose inputs are bit, valid, clear, len and pattern and whose output is hit.

Verification
REQ-035 SHALL test: pattern 10110, len 5, overlap, stream 1,0,1,1,0,1,1,0 -> match on bits 5 and 8, match_cnt=2.
REQ-036 SHALL test: the same stream in non-overlap mode -> match on bit 5 only, match_cnt=1.
REQ-037 SHALL test: cfg_len=0, then cfg_len=9 -> cfg_err pulses each time, previous configuration intact.
REQ-038 SHALL test: target=2, pattern 11, len 2, overlap, stream 1,1,1 -> done pulse after bit 3, busy=0 afterwards.
REQ-039 SHALL test: CNT_W=2 with a continuous match stream -> match_cnt holds at 3.
REQ-040 SHALL test: rst low mid-run after bits 1,0,1 -> all outputs 0; after restart, bits 1,0 produce no match.
